// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared types and constants for the bit-serial subtractor
package serial_sub_pkg;

  // Default operand/result width.
  localparam int SERIAL_SUB_DEFAULT_W = 3;

  // Operation phases: wait for operands, shift one bit per clock, hold result.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } sub_state_e;

  // Counter width sized so W=1 and power-of-two W never wrap before the last step.
  function automatic int sub_cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_subtractor1.sv
// rtl/serial_subtractor_subtractor1.sv - one-bit full subtractor cell
module subtractor1 (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference bit and borrow out for a - b - bin.
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial W-bit subtractor, LSB first; SERIAL_SUB_SATURATE_EN clamps underflow to 0
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int W = SERIAL_SUB_DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         b_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] diff,
  output logic         b_out,
  output logic         busy
);

  localparam int CW = sub_cnt_width(W);
  localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

  sub_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic          borrow_q, borrow_d;
  logic [W-1:0]  diff_q, diff_d;
  logic          bout_q, bout_d;

  logic step_d;
  logic step_bout;

  subtractor1 u_sub (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (borrow_q),
    .d    (step_d),
    .bout (step_bout)
  );

  // Next-state: accept operands in IDLE, one bit step per SHIFT clock, hold in DONE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    borrow_d = borrow_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          borrow_d = b_in;
          cnt_d    = '0;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Result bits enter at the MSB so after W steps bit 0 sits at the LSB.
        diff_d         = diff_q >> 1;
        diff_d[W-1]    = step_d;
        a_d            = a_q >> 1;
        b_d            = b_q >> 1;
        borrow_d       = step_bout;
        cnt_d          = cnt_q + CW'(1);
        if (cnt_q == LAST_STEP) begin
          state_d = ST_DONE;
          bout_d  = step_bout;
`ifdef SERIAL_SUB_SATURATE_EN
          if (step_bout) begin
            diff_d = '0;
          end
`endif
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      borrow_q <= borrow_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
    end
  end

  // Handshake and status outputs decode directly from the state.
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    busy      = (state_q == ST_SHIFT) || (state_q == ST_DONE);
    diff      = diff_q;
    b_out     = bout_q;
  end

endmodule
